// File: rtl/bcd_seq_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_adder_pkg
// Brief    : Shared FSM encoding and BCD constants for the sequential adder.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_bcd_corr = 5'd6;
    localparam logic [4:0] c_bcd_max  = 5'd9;

    function automatic logic bcd_digit_invalid(input logic [3:0] digit);
        return ({1'b0, digit} > c_bcd_max);
    endfunction

endpackage : bcd_seq_adder_pkg
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational single-digit BCD add with decimal correction.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_seq_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] w_raw;
    logic [4:0] w_corr;

    assign w_raw  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    // The 5-bit wrap of the corrected value is harmless: only bits [3:0] are kept.
    assign w_corr = w_raw + c_bcd_corr;

    always_comb begin
        s  = w_raw[3:0];
        co = 1'b0;
        if (w_raw > c_bcd_max) begin
            s  = w_corr[3:0];
            co = 1'b1;
        end
    end

endmodule : bcd_digit_add
`default_nettype wire

// File: rtl/bcd_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_adder
// Brief    : Digit-serial packed-BCD adder, one digit per cycle, LSD first.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_adder
    import bcd_seq_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int c_w     = 4 * DIGITS;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [c_w-1:0]     a_q, a_d;
    logic [c_w-1:0]     b_q, b_d;
    logic [c_w-1:0]     sum_q, sum_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               fin_q, fin_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         w_dig_a;
    logic [3:0]         w_dig_b;
    logic [3:0]         w_dig_s;
    logic               w_dig_co;
    logic               w_op_err;

    assign w_dig_a = a_q[idx_q*4 +: 4];
    assign w_dig_b = b_q[idx_q*4 +: 4];

    bcd_digit_add u_digit (
        .a  (w_dig_a),
        .b  (w_dig_b),
        .ci (carry_q),
        .s  (w_dig_s),
        .co (w_dig_co)
    );

    // Operand validity is judged on the values being latched this edge.
    always_comb begin
        w_op_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_digit_invalid(a[i*4 +: 4]) || bcd_digit_invalid(b[i*4 +: 4])) begin
                w_op_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        fin_d   = fin_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    fin_d   = 1'b0;
                    cout_d  = 1'b0;
                    err_d   = w_op_err;
                end
            end
            ST_RUN: begin
                // fin_q marks that the top digit is already written; the
                // following cycle hands over to DONE.
                if (fin_q) begin
                    state_d = ST_DONE;
                end else begin
                    sum_d[idx_q*4 +: 4] = w_dig_s;
                    carry_d             = w_dig_co;
                    if (idx_q == c_last_idx) begin
                        fin_d  = 1'b1;
                        cout_d = w_dig_co;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            fin_q   <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            fin_q   <= fin_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule : bcd_seq_adder
`default_nettype wire

// File: tb/tb_bcd_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_adder
// Brief    : Self-checking bench for bcd_seq_adder (DIGITS=4), decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_adder;

    localparam int DIGITS = 4;
    localparam int c_w    = 4 * DIGITS;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_w-1:0] a;
    logic [c_w-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [c_w-1:0] sum;
    logic           cout;
    logic           err;

    int checks   = 0;
    int failures = 0;

    bcd_seq_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal arithmetic for valid operands, digit rule otherwise.
    function automatic void model(input logic [c_w-1:0] ma, input logic [c_w-1:0] mb,
                                  input logic mc, output logic [c_w-1:0] ms,
                                  output logic mco, output logic merr);
        longint va, vb, tot, lim;
        int     c, s;
        merr = 1'b0;
        va = 0; vb = 0; lim = 1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[i*4 +: 4] > 9 || mb[i*4 +: 4] > 9) merr = 1'b1;
            va  = va * 10 + longint'(ma[i*4 +: 4]);
            vb  = vb * 10 + longint'(mb[i*4 +: 4]);
            lim = lim * 10;
        end
        ms = '0;
        if (!merr) begin
            tot = va + vb + longint'(mc);
            mco = (tot >= lim);
            tot = tot % lim;
            for (int i = 0; i < DIGITS; i++) begin
                ms[i*4 +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mc);
            for (int i = 0; i < DIGITS; i++) begin
                s = int'(ma[i*4 +: 4]) + int'(mb[i*4 +: 4]) + c;
                if (s > 9) begin
                    ms[i*4 +: 4] = 4'((s + 6) % 16);
                    c = 1;
                end else begin
                    ms[i*4 +: 4] = 4'(s);
                    c = 0;
                end
            end
            mco = (c != 0);
        end
    endfunction

    function automatic logic [c_w-1:0] rand_bcd();
        logic [c_w-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // One operation: pulse start, scramble inputs, wait for done, check all.
    task automatic run_op(input string tag, input logic [c_w-1:0] oa,
                          input logic [c_w-1:0] ob, input logic oc,
                          input bit restart);
        logic [c_w-1:0] es;
        logic           eco, eerr;
        int             cyc;
        int             ndone;
        model(oa, ob, oc, es, eco, eerr);
        @(negedge clk);
        a = oa; b = ob; cin = oc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = c_w'($urandom); b = c_w'($urandom); cin = 1'($urandom);
        chk({tag, "_busy_run"}, 64'(busy), 64'd1);
        cyc   = 0;
        ndone = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (restart && cyc == 2) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'd5);
        chk({tag, "_sum"},  64'(sum),  64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_err"},  64'(err),  64'(eerr));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_idle"},  64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk({tag, "_no_extra_done"}, 64'(ndone), 64'd0);
        chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_err",  64'(err),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("v1234", 16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op("v9999p1", 16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op("v9999x2", 16'h9999, 16'h9999, 1'b1, 1'b0);
        run_op("restart", 16'h0456, 16'h0321, 1'b1, 1'b1);
        run_op("inv00a0", 16'h00A0, 16'h0000, 1'b0, 1'b0);
        run_op("invffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) run_op("rand_bcd", rand_bcd(), rand_bcd(), 1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++)  run_op("rand_raw", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Abort in the third RUN cycle.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_err",  64'(err),  64'd0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);

        run_op("post_rst", 16'h0005, 16'h0005, 1'b0, 1'b0);
        chk("post_rst_sum", 64'(sum), 64'h0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_seq_adder
`default_nettype wire

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-002 Parameter DIGITS, default 4, SHALL set the number of BCD digits per operand (legal range 1..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*DIGITS  operand B, packed BCD.
REQ-008 cin  input  1  decimal carry-in to digit 0.
REQ-009 busy  output  1  high from start acceptance until done deasserts.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 sum  output  4*DIGITS  packed BCD result, held until next accepted start.
REQ-012 cout  output  1  decimal carry-out of the most significant digit.
REQ-013 err  output  1  high with done if any latched operand digit exceeded 9; held with sum.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 IDLE->RUN on a clk edge with start=1: a, b and cin latched; digit index cleared to 0; err flag computed from the latched operands.
REQ-016 In RUN, each cycle SHALL process exactly one digit, least significant first, using the registered carry.
REQ-017 Per digit, s = a_d + b_d + c as a 5-bit value; if s > 9, the digit SHALL be (s+6) mod 16 with carry 1, else s[3:0] with carry 0.
REQ-018 After digit DIGITS-1 is written, RUN->DONE; cout SHALL equal the final carry.
REQ-019 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following clk edge k+DIGITS+1, where edge k is the start-sampling edge.
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing.
REQ-023 Input changes after acceptance SHALL NOT affect the operation in progress.
REQ-024 Invalid digits (>9) SHALL still be processed per REQ-017; err=1 SHALL be the only flag for them.
REQ-025 sum, cout and err SHALL hold their values in IDLE until the next accepted start.
REQ-026 sum SHALL be cleared to 0 on acceptance and filled digit by digit.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously, state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, and clear the carry and index registers.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse.
REQ-029 The first start after reset release SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2 bits), the BCD correction constant 6, and the digit limit 9.
REQ-031 Single-digit add-and-correct logic SHALL be one combinational sub-module, bcd_digit_add (a, b, ci -> s, co).
REQ-032 The digit index register SHALL be clog2(DIGITS) bits wide, min 1.
REQ-033 Each digit position SHALL be selected by index, not by shifting.

Verification (DIGITS=4)
REQ-034 a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0; done 5 cycles after start edge.
REQ-035 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0.
REQ-036 a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-037 Second start pulse 2 cycles after first -> ignored; exactly one done; sum from the first operands.
REQ-038 a=0x00A0, b=0x0000, cin=0 -> err=1 with done; sum=0x0100, cout=0.
REQ-039 rst_n low in the 3rd RUN cycle -> no done; all outputs 0; next start 0x0005+0x0005 -> sum=0x0010.
